// File: rtl/sys_ctrl_clkgen.sv
// -----------------------------------------------------------------------------
// sys_ctrl_clkgen
//   System controller placed directly behind the board clock and reset pins.
//   Buffers the board clock, builds a stretched system reset (asynchronous
//   assert, synchronous release), and generates a runtime-programmable,
//   glitch-free serial clock with one-cycle edge strobes.
//
//   Optional feature macro: SYSCTL_WDT_EN
//     Defined: a WDT_WIDTH-bit watchdog re-asserts rst when it reaches all ones
//     without a kick in that cycle. rst_cause_o then reads 2'b10 until the next
//     pin reset.
//     Undefined: no watchdog logic, wdt_kick_i is ignored, and rst_cause_o is
//     fixed at 2'b01.
//
// Ports
//   clk_i         board clock input
//   rst_i         asynchronous active-low pin reset
//   clk_enable    request to run SCLK
//   div_i         SCLK half-period minus 1, in clk cycles
//   wdt_kick_i    watchdog restart pulse
//   clk           buffered clock; every flop in this block runs on it
//   rst / rst_n   system reset, active high / active low
//   sclk_o        serial clock; idles at CPOL
//   sclk_rise_o   strobe on the PH_A->PH_B transition (sclk_o 0->1 when CPOL=0)
//   sclk_fall_o   strobe on the return to the idle level (1->0 when CPOL=0)
//   sclk_active_o high while the SCLK FSM is not IDLE
//   rst_cause_o   2'b01 = pin reset, 2'b10 = watchdog reset
// -----------------------------------------------------------------------------
module sys_ctrl_clkgen #(
  parameter int SYNC_STAGES = 2,
  parameter int RST_HOLD    = 16,
  parameter int DIV_WIDTH   = 8,
  parameter bit CPOL        = 1'b0,
  parameter int WDT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clk_enable,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 wdt_kick_i,
  output logic                 clk,
  output logic                 rst,
  output logic                 rst_n,
  output logic                 sclk_o,
  output logic                 sclk_rise_o,
  output logic                 sclk_fall_o,
  output logic                 sclk_active_o,
  output logic [1:0]           rst_cause_o
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [DIV_WIDTH-1:0] CNT_ONE   = DIV_WIDTH'(1);
  localparam logic                 IDLE_LVL  = CPOL;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH_A = 2'd1,
    ST_PH_B = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [HOLD_W-1:0]      r_hold;
  logic                   r_rst;
  logic                   w_wdt_fire;

  state_t                 r_state, w_state_nxt;
  logic [DIV_WIDTH-1:0]   r_cnt, w_cnt_nxt;
  logic [DIV_WIDTH-1:0]   r_div_q, w_div_nxt;
  logic                   w_half_done;
  logic                   r_sclk, w_sclk_nxt;
  logic                   r_rise, w_rise_nxt;
  logic                   r_fall, w_fall_nxt;
  logic                   r_active;

  // Board clock through the input buffer. A vendor buffer primitive would be
  // instantiated here; the behavioural pass-through keeps the block portable.
  assign clk = clk_i;

  // Reset synchroniser and hold counter: assert asynchronously, release after
  // SYNC_STAGES + RST_HOLD edges. A watchdog bite re-asserts and reloads the hold.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_sync <= '0;
      r_hold <= '0;
      r_rst  <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
      if (w_wdt_fire) begin
        r_rst  <= 1'b1;
        r_hold <= '0;
      end else if (r_rst && r_sync[SYNC_STAGES-1]) begin
        if (r_hold == HOLD_LAST) begin
          r_rst <= 1'b0;
        end else begin
          r_hold <= r_hold + HOLD_W'(1);
        end
      end
    end
  end

  assign rst   = r_rst;
  assign rst_n = ~r_rst;

`ifdef SYSCTL_WDT_EN
  logic [WDT_WIDTH-1:0] r_wdt;
  logic [1:0]           r_cause;

  assign w_wdt_fire = !r_rst && (&r_wdt) && !wdt_kick_i;

  // Watchdog counter and sticky reset-cause register.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_wdt   <= '0;
      r_cause <= 2'b01;
    end else begin
      if (r_rst || w_wdt_fire || wdt_kick_i) begin
        r_wdt <= '0;
      end else begin
        r_wdt <= r_wdt + WDT_WIDTH'(1);
      end
      if (w_wdt_fire) begin
        r_cause <= 2'b10;
      end
    end
  end

  assign rst_cause_o = r_cause;
`else
  localparam int unused_wdt_width = WDT_WIDTH;
  logic w_unused_kick;
  assign w_unused_kick = wdt_kick_i;
  assign w_wdt_fire    = 1'b0;
  assign rst_cause_o   = 2'b01;
`endif

  assign w_half_done = (r_cnt == r_div_q);

  // SCLK FSM state register, together with the registered SCLK outputs.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_div_q  <= '0;
      r_sclk   <= IDLE_LVL;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_div_q  <= w_div_nxt;
      r_sclk   <= w_sclk_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      r_active <= (w_state_nxt != ST_IDLE);
    end
  end

  // SCLK FSM next state, half-period counter, and divider capture. div_i is
  // only sampled when a period starts, so mid-period changes cannot produce runts.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div_q;
    if (r_rst || w_wdt_fire) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = '0;
          if (clk_enable) begin
            w_state_nxt = ST_PH_A;
            w_div_nxt   = div_i;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_PH_A: begin
          if (w_half_done) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_PH_B;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ST_PH_B: begin
          if (w_half_done) begin
            w_cnt_nxt = '0;
            // A dropped enable always lets the full period finish first.
            if (clk_enable) begin
              w_state_nxt = ST_PH_A;
              w_div_nxt   = div_i;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // SCLK output decode: next level and strobes. These are registered above,
  // so the strobes line up exactly with the edges of sclk_o.
  always_comb begin
    w_sclk_nxt = IDLE_LVL;
    w_rise_nxt = 1'b0;
    w_fall_nxt = 1'b0;
    if (r_rst || w_wdt_fire) begin
      w_sclk_nxt = IDLE_LVL;
    end else begin
      case (r_state)
        ST_IDLE: w_sclk_nxt = IDLE_LVL;
        ST_PH_A: begin
          if (w_half_done) begin
            w_sclk_nxt = ~IDLE_LVL;
            w_rise_nxt = 1'b1;
          end else begin
            w_sclk_nxt = IDLE_LVL;
          end
        end
        ST_PH_B: begin
          if (w_half_done) begin
            w_sclk_nxt = IDLE_LVL;
            w_fall_nxt = 1'b1;
          end else begin
            w_sclk_nxt = ~IDLE_LVL;
          end
        end
        default: w_sclk_nxt = IDLE_LVL;
      endcase
    end
  end

  assign sclk_o        = r_sclk;
  assign sclk_rise_o   = r_rise;
  assign sclk_fall_o   = r_fall;
  assign sclk_active_o = r_active;

endmodule

// File: doc/sys_ctrl_clkgen.md
Name: sys_ctrl_clkgen

Overview:
- Parametrised system controller for the SPI FPGA. It generates the clock, reset and SPI serial clock for all downstream logic.
- Buffers the board clock and produces a reset that asserts asynchronously, deasserts synchronously and is stretched.
- Generates a runtime-programmable, glitch-free SCLK with edge strobes and a CPOL option.
- Sits at the top of the design, directly behind the clock and reset pins.

Parameters:
- SYNC_STAGES, 2: reset synchroniser depth; minimum 2.
- RST_HOLD, 16: clocks that rst stays asserted after the synchroniser releases; minimum 1.
- DIV_WIDTH, 8: width of the SCLK half-period divider.
- CPOL, 0: SCLK idle level.
- WDT_WIDTH, 16: watchdog counter width. Used only with SYSCTL_WDT_EN.

Ports:
- clk_i  input  1  board clock. Reset is asynchronous and active-low on rst_i.
- rst_i  input  1  asynchronous, active-low reset (0 = reset).
- clk_enable  input  1  request to run SCLK.
- div_i  input  DIV_WIDTH  SCLK half-period minus 1, in clk cycles.
- wdt_kick_i  input  1  watchdog restart pulse. Ignored unless SYSCTL_WDT_EN is defined.
- clk  output  1  clk_i through an input buffer primitive. All internal flops run on clk.
- rst  output  1  active-high system reset.
- rst_n  output  1  always the inverse of rst.
- sclk_o  output  1  serial clock.
- sclk_rise_o  output  1  one-cycle strobe, coincident with sclk_o going 0->1.
- sclk_fall_o  output  1  one-cycle strobe, coincident with sclk_o going 1->0.
- sclk_active_o  output  1  high whenever the SCLK FSM is not IDLE.
- rst_cause_o  output  2  01 = pin reset, 10 = watchdog reset.

Behaviour:
- Reset values while rst_i=0:
  - rst=1, rst_n=0, sclk_o=CPOL, strobes=0, sclk_active_o=0, rst_cause_o=01.
  - Synchroniser and hold counter are cleared.
  - All of the above take effect asynchronously.
- Reset release:
  - rst_i rises; the synchroniser shifts in 1s.
  - The hold counter then counts RST_HOLD clocks.
  - rst falls on the (SYNC_STAGES+RST_HOLD)th rising clk edge after rst_i is sampled high. Defaults: 18th edge.
- If rst_i drops mid-sequence, or while running: immediate asynchronous return to the reset values, and the sequence restarts.
- The SCLK FSM is held in IDLE while rst=1.
- SCLK FSM states: IDLE, PH_A (sclk_o=CPOL), PH_B (sclk_o=~CPOL). A half-period counter counts 0..div_q.
- IDLE:
  - sclk_o=CPOL, counter=0.
  - If clk_enable=1 at an edge: div_q<=div_i, go to PH_A.
- PH_A:
  - Counter increments each cycle.
  - When counter==div_q: counter<=0, sclk_o<=~CPOL, go to PH_B, pulse the matching strobe in the same cycle.
- PH_B:
  - Counter increments each cycle.
  - When counter==div_q: sclk_o<=CPOL, pulse the matching strobe, counter<=0.
  - If clk_enable=1 at that edge: div_q<=div_i, go to PH_A. Otherwise go to IDLE.
- Timing: each half lasts div_q+1 clocks, so the period is 2*(div_q+1).
  - div_i=0 gives clk/2.
  - The first active edge comes div_q+1 clocks after leaving IDLE.
- Glitch-free rules:
  - div_i is sampled only at IDLE exit and at period end. Changes mid-period take effect next period.
  - clk_enable deassertion always completes the current full period. No runt pulse.
  - Reasserting clk_enable before period end continues without a gap.
- sclk_o and the strobes are registered outputs with no combinational path from inputs.
- CPOL=1: the rise strobe marks the PH_A->PH_B transition; the fall strobe marks the return to idle level.
- Counter comparison is an unsigned equality check at DIV_WIDTH bits. Maximum div_i (all ones) gives a period of 2^(DIV_WIDTH+1) clocks with no overflow.

Optional Feature:
- Macro SYSCTL_WDT_EN.
- Defined:
  - A WDT_WIDTH counter, cleared while rst=1, increments each clock while rst=0.
  - wdt_kick_i=1 clears it.
  - On reaching all ones (without a kick that same cycle), rst asserts synchronously at the next edge.
  - rst_cause_o<=10, the SCLK FSM goes to IDLE immediately, and the hold counter reloads.
  - rst deasserts after RST_HOLD clocks.
  - The watchdog counter restarts at 0.
  - rst_cause_o keeps 10 until the next pin reset.
- Undefined: no watchdog logic; wdt_kick_i is unused; rst_cause_o is constant 01.

Test Plan:
- Defaults. rst_i low for 5 clocks, then high -> rst=1 for exactly 18 edges and low on the 18th. rst_i pulsed low on edge 10 -> rst reasserts immediately and the count restarts.
- div_i=3, CPOL=0, clk_enable held 1 -> sclk_o period 8 clocks, first rise 4 clocks after leaving IDLE. Rise/fall strobes exactly one cycle, aligned to sclk_o changes.
- div_i=0 -> sclk_o toggles every clock. Change div_i to 5 mid-PH_A -> the current period keeps half=1 clock; the next period has half=6 clocks.
- clk_enable dropped one clock after a rise (div=4) -> sclk_o completes the high phase (5 clocks), returns to 0 and goes IDLE. sclk_active_o falls on the same edge. No extra strobe.
- CPOL=1, div_i=2 -> idle level 1, first fall 3 clocks after start, period 6, returns to 1 on stop.
- SYSCTL_WDT_EN, WDT_WIDTH=4, no kick -> rst asserts 16 clocks after release, holds 16 clocks, rst_cause_o=10. Kicking every 10 clocks -> rst never asserts.
